// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard 640x480 timing constants, pixel type and
// capture state encoding.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } cap_state_t;

  // Memory word layout for one pixel: zero pad byte above R, G, B.
  function automatic logic [31:0] pixel_word(input pixel_t p);
    return {8'h00, p};
  endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Input register stage (S1) plus the delayed copy (S2) used to detect the
// vsync falling edge and the end of each active line.
module vga_edge_sync
  import vga_pkg::*;
(
  input  logic   clock_25,
  input  logic   reset,
  input  pixel_t pixel_in,
  input  logic   hsync_in,
  input  logic   vsync_in,
  input  logic   n_blank_in,
  output pixel_t pixel_s1,
  output logic   hsync_s1,
  output logic   n_blank_s1,
  output logic   vs_fall,
  output logic   line_end
);

  logic vsync_s1_r;
  logic vsync_s2_r;
  logic n_blank_s2_r;

  // S1/S2 pipeline; reset to idle video levels so no false edge follows reset.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      pixel_s1     <= '0;
      hsync_s1     <= 1'b1;
      vsync_s1_r   <= 1'b1;
      n_blank_s1   <= 1'b0;
      vsync_s2_r   <= 1'b1;
      n_blank_s2_r <= 1'b0;
    end else begin
      pixel_s1     <= pixel_in;
      hsync_s1     <= hsync_in;
      vsync_s1_r   <= vsync_in;
      n_blank_s1   <= n_blank_in;
      vsync_s2_r   <= vsync_s1_r;
      n_blank_s2_r <= n_blank_s1;
    end
  end

  assign vs_fall  = vsync_s2_r & ~vsync_s1_r;
  assign line_end = n_blank_s2_r & ~n_blank_s1;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one VGA frame into word-addressed memory, one 32-bit word per
// pixel, with a sticky error flag for malformed lines or truncated frames.
module vga_frame_capture
  import vga_pkg::*;
#(
  parameter int          IMG_W     = H_ACTIVE,
  parameter int          IMG_H     = V_ACTIVE,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        n_blank_in,
  output logic [31:0] address,
  output logic [31:0] wdata,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam logic [9:0] IMG_W_C = 10'(IMG_W);
  localparam logic [9:0] IMG_H_C = 10'(IMG_H);

  pixel_t     pixel_in_s;
  pixel_t     pixel_s1;
  logic       hsync_s1_unused;
  logic       n_blank_s1;
  logic       vs_fall;
  logic       line_end;

  cap_state_t  state_r,    next_state_s;
  logic [9:0]  x_r,        x_s;
  logic [9:0]  y_r,        y_s;
  logic [31:0] addr_cnt_r, addr_cnt_s;
  logic [31:0] address_s;
  logic [31:0] wdata_s;
  logic        we_s;
  logic        busy_s;
  logic        done_s;
  logic        frame_err_s;

  assign pixel_in_s = {red_in, green_in, blue_in};

  vga_edge_sync u_edge_sync (
    .clock_25   (clock_25),
    .reset      (reset),
    .pixel_in   (pixel_in_s),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .n_blank_in (n_blank_in),
    .pixel_s1   (pixel_s1),
    .hsync_s1   (hsync_s1_unused),
    .n_blank_s1 (n_blank_s1),
    .vs_fall    (vs_fall),
    .line_end   (line_end)
  );

  // Next-state, counters and the values the output registers will load.
  always_comb begin
    next_state_s = state_r;
    x_s          = x_r;
    y_s          = y_r;
    addr_cnt_s   = addr_cnt_r;
    address_s    = address;
    wdata_s      = wdata;
    we_s         = 1'b0;
    busy_s       = busy;
    done_s       = 1'b0;
    frame_err_s  = frame_err;

    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = ARMED;
          x_s          = 10'd0;
          y_s          = 10'd0;
          addr_cnt_s   = BASE_ADDR;
          frame_err_s  = 1'b0;
          busy_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end

      ARMED: begin
        if (vs_fall) begin
          next_state_s = CAPTURE;
        end else begin
          next_state_s = ARMED;
        end
      end

      CAPTURE: begin
        if (n_blank_s1) begin
          if (x_r < IMG_W_C) begin
            we_s       = 1'b1;
            address_s  = addr_cnt_r;
            wdata_s    = pixel_word(pixel_s1);
            x_s        = x_r + 10'd1;
            addr_cnt_s = addr_cnt_r + 32'd1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          x_s = x_r;
        end

        if (line_end) begin
          if (x_r != IMG_W_C) begin
            frame_err_s = 1'b1;
          end else begin
            frame_err_s = frame_err_s;
          end
          x_s = 10'd0;
          y_s = y_r + 10'd1;
        end else begin
          y_s = y_r;
        end

        // A completed last line wins over a coincident vsync fall.
        if (line_end && (y_r + 10'd1 == IMG_H_C)) begin
          next_state_s = FINISH;
        end else if (vs_fall) begin
          next_state_s = FINISH;
          frame_err_s  = 1'b1;
        end else begin
          next_state_s = CAPTURE;
        end
      end

      FINISH: begin
        next_state_s = IDLE;
        busy_s       = 1'b0;
        done_s       = 1'b1;
      end

      default: begin
        next_state_s = IDLE;
        busy_s       = 1'b0;
      end
    endcase
  end

  // State, counters and registered memory/status outputs.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      addr_cnt_r <= BASE_ADDR;
      address    <= BASE_ADDR;
      wdata      <= 32'd0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      x_r        <= x_s;
      y_r        <= y_s;
      addr_cnt_r <= addr_cnt_s;
      address    <= address_s;
      wdata      <= wdata_s;
      we         <= we_s;
      busy       <= busy_s;
      done       <= done_s;
      frame_err  <= frame_err_s;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced 16x8 image: scoreboard of expected
// (address, wdata) pairs filled by the stimulus and drained by the write monitor.
module tb_vga_frame_capture;

  localparam int          W           = 16;
  localparam int          H           = 8;
  localparam logic [31:0] BASE        = 32'hFFFF_FFC0;
  localparam int          BLANK       = 8;
  localparam int          FRAME_LINES = 12;
  localparam int          FIRST_ACT   = 3;

  logic        clock_25 = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic [7:0]  red_in   = 8'd0;
  logic [7:0]  green_in = 8'd0;
  logic [7:0]  blue_in  = 8'd0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        n_blank_in = 1'b0;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        we;
  logic        busy;
  logic        done;
  logic        frame_err;

  int          checks      = 0;
  int          failures    = 0;
  int          cyc         = 0;
  int          writes      = 0;
  int          done_cnt    = 0;
  int          exp_done_cyc = -1;
  logic [31:0] exp_addr_cnt = BASE;
  logic [31:0] last_addr   = 32'd0;
  logic [31:0] word32      = 32'd0;
  logic        got32       = 1'b0;
  logic [63:0] exp_q[$];

  vga_frame_capture #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE)) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .start      (start),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .n_blank_in (n_blank_in),
    .address    (address),
    .wdata      (wdata),
    .we         (we),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err)
  );

  always #20 clock_25 = ~clock_25;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] px_word(input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = x[7:0];
    yb = y[7:0];
    return {8'h00, xb, yb, 8'hA5};
  endfunction

  initial forever begin
    @(posedge clock_25);
    cyc++;
  end

  // Write/done monitor, sampled on the falling edge.
  initial forever begin
    logic [63:0] e;
    @(negedge clock_25);
    if (reset && we) begin
      writes++;
      last_addr = address;
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", {31'd0, we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("address", address, e[63:32]);
        check_eq("wdata", wdata, e[31:0]);
      end
      if (address == BASE + 32'(2 * W + 3)) begin
        word32 = wdata;
        got32  = 1'b1;
      end
    end
    if (reset && done) begin
      done_cnt++;
      check_eq("done_timing", cyc, exp_done_cyc);
    end
  end

  task automatic arm();
    @(negedge clock_25);
    start        = 1'b1;
    exp_addr_cnt = BASE;
    @(negedge clock_25);
    start = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    check_eq("err_cleared", {31'd0, frame_err}, 32'd0);
  endtask

  // One frame: 2 vsync lines, 1 back porch, 8 active slots, 1 front porch.
  task automatic drive_frame(input bit exp_wr, input int n_act, input int short_a,
                             input int long_a, input int start_ln, input int start_col,
                             input int rst_ln, input int rst_col, input bit done_on_vs);
    bit          wr;
    int          a;
    int          len;
    logic [31:0] pw;
    wr = exp_wr;
    for (int ln = 0; ln < FRAME_LINES; ln++) begin
      a   = ln - FIRST_ACT;
      len = (a == short_a) ? W - 1 : ((a == long_a) ? W + 1 : W);
      for (int col = 0; col < len + BLANK; col++) begin
        @(negedge clock_25);
        vsync_in = (ln < 2) ? 1'b0 : 1'b1;
        hsync_in = (col >= len + 2 && col < len + 5) ? 1'b0 : 1'b1;
        start    = (ln == start_ln && col == start_col);
        if (start) exp_addr_cnt = BASE;
        if (ln == 0 && col == 0 && done_on_vs) exp_done_cyc = cyc + 3;
        if (a >= 0 && a < n_act && col < len) begin
          pw = px_word(col, a);
          n_blank_in = 1'b1;
          {red_in, green_in, blue_in} = pw[23:0];
          if (wr && col < W) begin
            exp_q.push_back({exp_addr_cnt, pw});
            exp_addr_cnt = exp_addr_cnt + 32'd1;
          end
        end else begin
          n_blank_in = 1'b0;
          {red_in, green_in, blue_in} = 24'd0;
          if (wr && a == H - 1 && n_act == H && col == len) exp_done_cyc = cyc + 3;
        end
        if (ln == rst_ln && col == rst_col) begin
          #1 reset = 1'b0;
          #1;
          check_eq("rst_we", {31'd0, we}, 32'd0);
          check_eq("rst_busy", {31'd0, busy}, 32'd0);
          check_eq("rst_address", address, BASE);
          exp_q.delete();
          wr     = 1'b0;
          writes = 0;
          @(posedge clock_25);
          #1 reset = 1'b1;
        end
      end
    end
    @(negedge clock_25);
    start      = 1'b0;
    vsync_in   = 1'b1;
    hsync_in   = 1'b1;
    n_blank_in = 1'b0;
  endtask

  task automatic end_test(input int exp_writes, input logic exp_err, input int exp_done);
    repeat (4) @(negedge clock_25);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    check_eq("write_count", writes, exp_writes);
    check_eq("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    check_eq("done_count", done_cnt, exp_done);
    check_eq("busy_end", {31'd0, busy}, 32'd0);
    exp_q.delete();
    writes       = 0;
    done_cnt     = 0;
    exp_done_cyc = -1;
  endtask

  initial begin
    repeat (2) @(negedge clock_25);
    check_eq("reset_address", address, BASE);
    check_eq("reset_wdata", wdata, 32'd0);
    check_eq("reset_we", {31'd0, we}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock_25);

    // Clean frame; addresses wrap through zero from BASE.
    arm();
    drive_frame(1'b1, H, -1, -1, -1, -1, -1, -1, 1'b0);
    end_test(W * H, 1'b0, 1);
    check_eq("word_3_2_seen", {31'd0, got32}, 32'd1);
    check_eq("word_3_2", word32, 32'h0003_02A5);
    check_eq("last_addr", last_addr, BASE + 32'(W * H - 1));

    // Start mid-frame: nothing until the next vsync fall.
    drive_frame(1'b0, H, -1, -1, FIRST_ACT + 3, 2, -1, -1, 1'b0);
    drive_frame(1'b1, H, -1, -1, -1, -1, -1, -1, 1'b0);
    end_test(W * H, 1'b0, 1);

    // Start coincident with vs_fall: that frame is skipped.
    drive_frame(1'b0, H, -1, -1, 0, 1, -1, -1, 1'b0);
    drive_frame(1'b1, H, -1, -1, -1, -1, -1, -1, 1'b0);
    end_test(W * H, 1'b0, 1);

    // Short line 5.
    arm();
    drive_frame(1'b1, H, 5, -1, -1, -1, -1, -1, 1'b0);
    end_test(W * H - 1, 1'b1, 1);

    // Long line 3.
    arm();
    drive_frame(1'b1, H, -1, 3, -1, -1, -1, -1, 1'b0);
    end_test(W * H, 1'b1, 1);

    // Truncated frame: vsync fall after 3 lines.
    arm();
    drive_frame(1'b1, 3, -1, -1, -1, -1, -1, -1, 1'b0);
    drive_frame(1'b0, 0, -1, -1, -1, -1, -1, -1, 1'b1);
    end_test(3 * W, 1'b1, 1);

    // Reset mid-frame, then a clean re-armed capture.
    arm();
    drive_frame(1'b1, H, -1, -1, -1, -1, FIRST_ACT + 4, 5, 1'b0);
    end_test(0, 1'b0, 0);
    arm();
    drive_frame(1'b1, H, -1, -1, -1, -1, -1, -1, 1'b0);
    end_test(W * H, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
